// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface if_fetch_unit_if #(
  parameter int XLEN = 32
) ();
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps at most one imem request in flight and
// buffers responses in a 2-entry FIFO that feeds IF/ID; EXE redirects flush it.
module if_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_stall,
  input  logic            exe_redirect,
  input  logic [XLEN-1:0] exe_redirect_pc,
  if_fetch_unit_if.master imem,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t [1:0]    fifo_q, fifo_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            outst_q, outst_d;
  logic            kill_q, kill_d;

  logic            pop, push, req, grant;
  logic [2:0]      occ;
  logic [1:0]      wsel;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^exe_redirect_pc[1:0];

  assign if_id_valid = (cnt_q != 2'd0);
  assign if_id_pc    = if_id_valid ? fifo_q[0].pc    : '0;
  assign if_id_instr = if_id_valid ? fifo_q[0].instr : NOP_INSTR;

  assign pop = if_id_valid && !if_stall;
  // Slots committed after this edge: buffered + in flight - leaving now.
  assign occ = 3'(cnt_q) + 3'(outst_q) - 3'(pop);
  assign req = rst_n && !exe_redirect && !kill_q &&
               (!outst_q || imem.rvalid) && (occ < 3'd2);
  assign grant = req && imem.gnt;
  assign push  = imem.rvalid && !kill_q;
  assign wsel  = cnt_q - 2'(pop);

  assign imem.req  = req;
  assign imem.addr = fetch_pc_q;

  always_comb begin
    fifo_d     = fifo_q;
    cnt_d      = cnt_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    outst_d    = outst_q;
    kill_d     = kill_q;
    if (exe_redirect) begin
      cnt_d      = 2'd0;
      fetch_pc_d = {exe_redirect_pc[XLEN-1:2], 2'b00};
      // A response landing this cycle retires the in-flight request; otherwise
      // it is still coming and must be dropped when it arrives.
      outst_d    = outst_q && !imem.rvalid;
      kill_d     = outst_q && !imem.rvalid;
    end else begin
      if (imem.rvalid) begin
        outst_d = 1'b0;
        kill_d  = 1'b0;
      end
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        req_pc_d   = fetch_pc_q;
        outst_d    = 1'b1;
      end
      if (pop) fifo_d[0] = fifo_q[1];
      if (push) fifo_d[wsel[0]] = '{pc: req_pc_q, instr: imem.rdata};
      cnt_d = cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_q     <= '0;
      cnt_q      <= 2'd0;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      outst_q    <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      cnt_q      <= cnt_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      outst_q    <= outst_d;
      kill_q     <= kill_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: behavioural imem with programmable latency,
// per-cycle expected req/addr/IF-ID values worked out by hand.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        if_stall;
  logic        exe_redirect;
  logic [31:0] exe_redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int checks = 0;
  int errors = 0;

  if_fetch_unit_if #(.XLEN(32)) imem_if ();

  if_fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_stall(if_stall),
    .exe_redirect(exe_redirect), .exe_redirect_pc(exe_redirect_pc),
    .imem(imem_if),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: grant in cycle c answers in cycle c+lat with {addr[31:2],2'b11}.
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (imem_if.rvalid && mq_addr.size() > 0) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_if.req && imem_if.gnt) begin
        mq_addr.push_back(imem_if.addr);
        mq_due.push_back(cyc + lat);
      end
    end
    cyc++;
    #1;
    if (mq_addr.size() > 0 && mq_due[0] == cyc) begin
      imem_if.rvalid = 1'b1;
      imem_if.rdata  = {mq_addr[0][31:2], 2'b11};
    end else begin
      imem_if.rvalid = 1'b0;
      imem_if.rdata  = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample mid-cycle; addr is only meaningful while a request is up.
  task automatic look(input string tag, input logic ereq, input logic [31:0] eaddr,
                      input logic evld, input logic [31:0] epc);
    logic [31:0] einstr;
    einstr = evld ? {epc[31:2], 2'b11} : 32'h0000_0013;
    @(negedge clk);
    chk({tag, "_req"}, 32'(imem_if.req), 32'(ereq));
    if (ereq) chk({tag, "_addr"}, imem_if.addr, eaddr);
    chk({tag, "_vld"}, 32'(if_id_valid), 32'(evld));
    chk({tag, "_pc"}, if_id_pc, evld ? epc : 32'h0);
    chk({tag, "_ins"}, if_id_instr, einstr);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; exe_redirect = 1'b0; if_stall = 1'b0; imem_if.gnt = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; if_stall = 1'b0; exe_redirect = 1'b0;
    exe_redirect_pc = 32'h0; imem_if.gnt = 1'b1;
    repeat (3) tick();
    look("rst", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_addr", imem_if.addr, 32'h0000_0100);

    // Streaming with 1-cycle memory, then a 5-cycle stall.
    tick(); rst_n = 1'b1;
    look("a0", 1'b1, 32'h100, 1'b0, 32'h0);
    tick(); look("a1", 1'b1, 32'h104, 1'b0, 32'h0);
    tick(); look("a2", 1'b1, 32'h108, 1'b1, 32'h100);
    tick(); look("a3", 1'b1, 32'h10C, 1'b1, 32'h104);
    tick(); look("a4", 1'b1, 32'h110, 1'b1, 32'h108);
    tick(); if_stall = 1'b1;
    look("s5", 1'b0, 32'h0, 1'b1, 32'h10C);
    for (int i = 0; i < 4; i++) begin
      tick(); look("s6_9", 1'b0, 32'h0, 1'b1, 32'h10C);
    end
    tick(); if_stall = 1'b0;
    look("s10", 1'b1, 32'h114, 1'b1, 32'h10C);
    tick(); look("s11", 1'b1, 32'h118, 1'b1, 32'h110);
    tick(); look("s12", 1'b1, 32'h11C, 1'b1, 32'h114);
    tick(); look("s13", 1'b1, 32'h120, 1'b1, 32'h118);

    // Redirect to an unaligned target while a 3-cycle fetch is in flight.
    lat = 3;
    do_reset();
    look("c0", 1'b1, 32'h100, 1'b0, 32'h0);
    tick(); look("c1", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); look("c2", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); look("c3", 1'b1, 32'h104, 1'b0, 32'h0);
    tick(); exe_redirect = 1'b1; exe_redirect_pc = 32'h0000_0203;
    look("c4", 1'b0, 32'h0, 1'b1, 32'h100);
    tick(); exe_redirect = 1'b0;
    look("c5", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); look("c6", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); look("c7", 1'b1, 32'h200, 1'b0, 32'h0);
    tick(); look("c8", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); look("c9", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); look("c10", 1'b1, 32'h204, 1'b0, 32'h0);
    tick(); look("c11", 1'b0, 32'h0, 1'b1, 32'h200);

    // Redirect and stall together with the FIFO full.
    lat = 1;
    do_reset();
    look("d0", 1'b1, 32'h100, 1'b0, 32'h0);
    repeat (4) tick();
    tick(); if_stall = 1'b1;
    look("d5", 1'b0, 32'h0, 1'b1, 32'h10C);
    tick(); exe_redirect = 1'b1; exe_redirect_pc = 32'h0000_0302;
    look("d6", 1'b0, 32'h0, 1'b1, 32'h10C);
    tick(); exe_redirect = 1'b0; if_stall = 1'b0;
    look("d7", 1'b1, 32'h300, 1'b0, 32'h0);
    tick(); look("d8", 1'b1, 32'h304, 1'b0, 32'h0);

    // Redirect to the top of the address space, grant withheld, then wrap.
    tick(); exe_redirect = 1'b1; exe_redirect_pc = 32'hFFFF_FFFF; imem_if.gnt = 1'b0;
    look("e9", 1'b0, 32'h0, 1'b1, 32'h300);
    tick(); exe_redirect = 1'b0;
    look("e10", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); look("e11_13", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    end
    tick(); imem_if.gnt = 1'b1;
    look("e14", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tick(); look("e15", 1'b1, 32'h0, 1'b0, 32'h0);
    tick(); look("e16", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC);
    tick(); look("e17", 1'b1, 32'h8, 1'b1, 32'h0);

    // Reset with a 3-cycle response still pending.
    lat = 3;
    do_reset();
    look("f0", 1'b1, 32'h100, 1'b0, 32'h0);
    tick(); look("f1", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); rst_n = 1'b0;
    look("f2", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); look("f3", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("f3_addr", imem_if.addr, 32'h0000_0100);
    tick(); rst_n = 1'b1;
    look("f4", 1'b1, 32'h100, 1'b0, 32'h0);
    tick(); look("f5", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); look("f6", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); look("f7", 1'b1, 32'h104, 1'b0, 32'h0);
    tick(); look("f8", 1'b0, 32'h0, 1'b1, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
